// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide issue controller with fixed-latency countdown.
// It owns the HI/LO registers and raises a D-stage stall while the unit is occupied.
`default_nettype none

module mdu_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic        op_valid,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_md_req,
  output logic        start,
  output logic        busy,
  output logic        stall_D,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rdata
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) > 4) ? $clog2(MAX_CYCLES + 1) : 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [31:0]        pend_hi;
  logic [31:0]        pend_lo;
  logic               pend_wr;

  logic               is_md;
  logic [63:0]        mul_s;
  logic [63:0]        mul_u;
  logic [31:0]        div_b;
  logic [31:0]        abs_a;
  logic [31:0]        abs_b;
  logic [31:0]        mag_q;
  logic [31:0]        mag_r;
  logic [31:0]        sdiv_q;
  logic [31:0]        sdiv_r;
  logic [31:0]        udiv_q;
  logic [31:0]        udiv_r;

  assign is_md   = op_valid && (md_op >= 4'd1) && (md_op <= 4'd4);
  assign start   = is_md && (state == IDLE);
  assign stall_D = d_md_req && (start || busy);

  always_comb begin
    rdata = 32'd0;
    if (op_valid) begin
      if (md_op == 4'd5)      rdata = hi;
      else if (md_op == 4'd6) rdata = lo;
    end
  end

  // Signed division is done on magnitudes so 0x80000000 / -1 yields 0x80000000 without overflow.
  // A zero divisor is replaced by 1 only to keep the dividers defined; its result is never written.
  always_comb begin
    mul_s  = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
    mul_u  = {32'd0, src_a} * {32'd0, src_b};
    div_b  = (src_b == 32'd0) ? 32'd1 : src_b;
    abs_a  = src_a[31] ? (32'd0 - src_a) : src_a;
    abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
    mag_q  = abs_a / abs_b;
    mag_r  = abs_a % abs_b;
    sdiv_q = (src_a[31] ^ div_b[31]) ? (32'd0 - mag_q) : mag_q;
    sdiv_r = src_a[31] ? (32'd0 - mag_r) : mag_r;
    udiv_q = src_a / div_b;
    udiv_r = src_a % div_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            case (md_op)
              4'd1: begin
                {pend_hi, pend_lo} <= mul_s;
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= MULT;
              end
              4'd2: begin
                {pend_hi, pend_lo} <= mul_u;
                pend_wr <= 1'b1;
                cnt     <= CNT_W'(MULT_CYCLES);
                state   <= MULT;
              end
              4'd3: begin
                pend_hi <= sdiv_r;
                pend_lo <= sdiv_q;
                pend_wr <= (src_b != 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= DIV;
              end
              default: begin
                pend_hi <= udiv_r;
                pend_lo <= udiv_q;
                pend_wr <= (src_b != 32'd0);
                cnt     <= CNT_W'(DIV_CYCLES);
                state   <= DIV;
              end
            endcase
          end else if (op_valid && (md_op == 4'd7)) begin
            hi <= src_a;
          end else if (op_valid && (md_op == 4'd8)) begin
            lo <= src_a;
          end
        end
        MULT, DIV: begin
          cnt <= cnt - 1'b1;
          if (cnt == CNT_W'(1)) begin
            if (pend_wr) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mdu_sequencer.sv
// tb_mdu_sequencer: randomized and directed checks of mdu_sequencer against a 64-bit arithmetic model.
`default_nettype none

module tb_mdu_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic        op_valid;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        d_md_req;
  logic        start;
  logic        busy;
  logic        stall_D;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .op_valid(op_valid),
    .src_a(src_a), .src_b(src_b), .d_md_req(d_md_req),
    .start(start), .busy(busy), .stall_D(stall_D),
    .hi(hi), .lo(lo), .rdata(rdata)
  );

  always #5 clk = ~clk;

  function automatic int latency(input logic [3:0] op);
    return (op <= 4'd2) ? 5 : 10;
  endfunction

  // Architectural result of one MD op, using 64-bit host arithmetic.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      4'd1: begin p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0]; end
      4'd2: begin up = ua * ub; m_hi = up[63:32]; m_lo = up[31:0]; end
      4'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      4'd4: if (b != 32'd0) begin uq = ua / ub; ur = ua % ub; m_lo = uq[31:0]; m_hi = ur[31:0]; end
      default: ;
    endcase
  endtask

  // Caller is positioned in the low phase; the op issues in the current cycle.
  task automatic run_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    int n;
    n = 0;
    op_valid = 1'b1; md_op = op; src_a = a; src_b = b;
    #1;
    checks++;
    if (start !== 1'b1) $display("FAIL %s start: got %b want 1", name, start);
    if (start !== 1'b1) errors++;
    model(op, a, b);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      op_valid = 1'b0; md_op = 4'd0;
      #1;
      if (busy === 1'b1) n++;
      else break;
    end
    checks++;
    if (n != latency(op)) begin
      errors++;
      $display("FAIL %s busy_len: got %0d want %0d", name, n, latency(op));
    end
    checks++;
    if (hi !== m_hi) begin errors++; $display("FAIL %s hi: got %h want %h", name, hi, m_hi); end
    checks++;
    if (lo !== m_lo) begin errors++; $display("FAIL %s lo: got %h want %h", name, lo, m_lo); end
  endtask

  task automatic test_reset();
    reset = 1'b1; op_valid = 1'b0; md_op = 4'd0; src_a = '0; src_b = '0; d_md_req = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || start !== 1'b0 || stall_D !== 1'b0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b hi=%h lo=%h start=%b stall=%b rdata=%h want all zero",
               busy, hi, lo, start, stall_D, rdata);
    end
  endtask

  task automatic test_mult();
    @(negedge clk);
    run_md(4'd1, 32'hFFFF_FFFE, 32'd3, "mult_neg2x3");
    run_md(4'd2, 32'hFFFF_FFFE, 32'd3, "multu_x3");
  endtask

  task automatic test_div();
    @(negedge clk);
    run_md(4'd3, 32'hFFFF_FFF9, 32'd2, "div_neg7by2");
    run_md(4'd4, 32'd7, 32'd0, "divu_by0");
  endtask

  task automatic test_stall();
    logic want;
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk);
      d_md_req = (pass == 0);
      op_valid = 1'b1; md_op = 4'd1; src_a = $urandom; src_b = $urandom;
      model(4'd1, src_a, src_b);
      #1;
      checks++;
      if (stall_D !== d_md_req) begin
        errors++; $display("FAIL stall_issue pass%0d: got %b want %b", pass, stall_D, d_md_req);
      end
      for (int i = 1; i <= 6; i++) begin
        @(negedge clk);
        op_valid = 1'b0; md_op = 4'd0;
        #1;
        want = (pass == 0) && (i <= 5);
        checks++;
        if (stall_D !== want) begin
          errors++; $display("FAIL stall_cyc%0d pass%0d: got %b want %b", i, pass, stall_D, want);
        end
      end
      d_md_req = 1'b0;
    end
  endtask

  task automatic test_mthi_mflo();
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'd7; src_a = 32'h1234_5678;
    m_hi = 32'h1234_5678;
    @(negedge clk);
    md_op = 4'd5; src_a = 32'd0;
    #1;
    checks++;
    if (rdata !== 32'h1234_5678) begin errors++; $display("FAIL mfhi: got %h want 12345678", rdata); end
    @(negedge clk);
    md_op = 4'd8; src_a = 32'h0000_000A;
    m_lo = 32'h0000_000A;
    @(negedge clk);
    md_op = 4'd6; src_a = 32'd0;
    #1;
    checks++;
    if (rdata !== 32'h0000_000A) begin errors++; $display("FAIL mflo: got %h want 0000000a", rdata); end
    @(negedge clk);
    op_valid = 1'b0; md_op = 4'd5;
    #1;
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL rdata_invalid: got %h want 0", rdata); end
    md_op = 4'd0;
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    op_valid = 1'b1; md_op = 4'd3; src_a = 32'd1000; src_b = 32'd7;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      op_valid = 1'b0; md_op = 4'd0;
    end
    #1;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy4: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    checks++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      errors++; $display("FAIL middiv_reset: busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo);
    end
    run_md(4'd1, $urandom, $urandom, "mult_after_reset");
  endtask

  task automatic test_edge();
    int n;
    @(negedge clk);
    run_md(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, "div_overflow");
    // op_valid low: md_op must be ignored
    op_valid = 1'b0; md_op = 4'd1; src_a = 32'd3; src_b = 32'd4;
    #1;
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL novalid_start: got %b want 0", start); end
    @(negedge clk);
    md_op = 4'd0;
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL novalid_busy: got %b want 0", busy); end
    // divide by zero keeps HI/LO, so a dropped mthi during busy stays observable
    op_valid = 1'b1; md_op = 4'd4; src_a = 32'd5; src_b = 32'd0;
    @(negedge clk);
    md_op = 4'd7; src_a = 32'hDEAD_BEEF;
    @(negedge clk);
    md_op = 4'd1; src_a = 32'd9; src_b = 32'd9;
    #1;
    checks++;
    if (start !== 1'b0) begin errors++; $display("FAIL start_while_busy: got %b want 0", start); end
    op_valid = 1'b0; md_op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_stuck: got %b want 0", busy); end
    checks++;
    if (hi !== m_hi || lo !== m_lo) begin
      errors++; $display("FAIL mthi_while_busy: hi=%h lo=%h want %h %h", hi, lo, m_hi, m_lo);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  op;
    logic [31:0] a, b;
    @(negedge clk);
    for (int k = 0; k < 24; k++) begin
      op = 4'($urandom_range(1, 4));
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (k % 5 == 1) a = 32'h8000_0000;
      if (k % 7 == 3) b = 32'hFFFF_FFFF;
      run_md(op, a, b, "b2b_random");
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_stall();
    test_mthi_mflo();
    test_reset_mid_div();
    test_edge();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
